cfu_idiv_responder: RTL and testbench

// CFU-LI level-2 responder: serial unsigned 32-bit divide/remainder unit behind a valid/ready request/response handshake.
// It is the responder end of the same CFU interface our TB initiators drive.
// It is the device under test for a new IDivTB in the top-level bench, using the shared cycle/lfsr stimulus.
// One request is in flight at a time. Restoring shift-subtract, one quotient bit per clock.

---
 rtl/cfu_idiv_responder.sv | 155 +++++++++++++++
 tb/tb_cfu_idiv_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_idiv_responder.sv
// CFU-LI level-2 responder: serial unsigned DIVU/REMU behind a valid/ready handshake.
// Restoring shift-subtract, one quotient bit per clock, one request in flight.
module cfu_idiv_responder #(
    parameter int CFU_VERSION        = 0,
    parameter int CFU_INTERFACE_ID_W = 16,
    parameter int CFU_FUNCTION_ID_W  = 1,
    parameter int CFU_REQ_RESP_ID_W  = 6,
    parameter int CFU_REQ_DATA_W     = 32,
    parameter int CFU_RESP_DATA_W    = CFU_REQ_DATA_W,
    parameter int CFU_STATUS_W       = 2,
    parameter int IID_IDIV           = 1001
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clock_en,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [CFU_INTERFACE_ID_W-1:0] req_interface_id,
    input  logic [CFU_FUNCTION_ID_W-1:0]  req_function_id,
    input  logic [CFU_REQ_RESP_ID_W-1:0]  req_id,
    input  logic [CFU_REQ_DATA_W-1:0]     req_data0,
    input  logic [CFU_REQ_DATA_W-1:0]     req_data1,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [CFU_REQ_RESP_ID_W-1:0]  resp_id,
    output logic [CFU_STATUS_W-1:0]       resp_status,
    output logic [CFU_RESP_DATA_W-1:0]    resp_data
);

    localparam int W     = CFU_REQ_DATA_W;
    localparam int CNT_W = $clog2(W + 1);

    localparam logic [CFU_STATUS_W-1:0]       ST_OK        = CFU_STATUS_W'(0);
    localparam logic [CFU_STATUS_W-1:0]       ST_ERR_IFACE = CFU_STATUS_W'(1);
    localparam logic [CFU_STATUS_W-1:0]       ST_ERR_FUNC  = CFU_STATUS_W'(2);
    localparam logic [CFU_INTERFACE_ID_W-1:0] IID          = CFU_INTERFACE_ID_W'(IID_IDIV);
    localparam logic [CNT_W-1:0]              CNT_LAST     = CNT_W'(1);

    if (CFU_VERSION < 0 || CFU_RESP_DATA_W != CFU_REQ_DATA_W || CFU_STATUS_W < 2) begin : g_bad_params
        $error("cfu_idiv_responder: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [W-1:0]                 quo, rem, dvs;
    logic [CNT_W-1:0]             cnt;
    logic                         func_rem;
    logic [CFU_REQ_RESP_ID_W-1:0] id_q;
    logic [CFU_STATUS_W-1:0]      status_q;
    logic [CFU_RESP_DATA_W-1:0]   data_q;

    logic         accept, bad_iid, bad_func, div_zero, fast_path;
    logic [W:0]   rem_shift;
    logic [W-1:0] rem_diff, rem_next, quo_next;
    logic         rem_ge;

    // Function ids above REMU only exist when the id field is wider than one bit.
    if (CFU_FUNCTION_ID_W > 1) begin : g_func_check
        assign bad_func = |req_function_id[CFU_FUNCTION_ID_W-1:1];
    end else begin : g_no_func_check
        assign bad_func = 1'b0;
    end

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        accept    = req_valid && req_ready;
        bad_iid   = (req_interface_id != IID);
        div_zero  = (req_data1 == '0);
        fast_path = bad_iid || bad_func || div_zero;
    end

    // The shifted remainder can reach W+1 bits; the difference always fits back in W.
    always_comb begin
        rem_shift = {rem, quo[W-1]};
        rem_ge    = (rem_shift >= {1'b0, dvs});
        rem_diff  = rem_shift[W-1:0] - dvs;
        rem_next  = rem_ge ? rem_diff : rem_shift[W-1:0];
        quo_next  = {quo[W-2:0], rem_ge};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else if (clock_en) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = fast_path ? S_RESP : S_BUSY;
            S_BUSY:  if (cnt == CNT_LAST) state_next = S_RESP;
            S_RESP:  if (resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            func_rem <= 1'b0;
            id_q     <= '0;
            status_q <= '0;
            data_q   <= '0;
        end else if (clock_en) begin
            if (accept) begin
                id_q     <= req_id;
                func_rem <= req_function_id[0];
                quo      <= req_data0;
                dvs      <= req_data1;
                rem      <= '0;
                cnt      <= CNT_W'(W);
                if (bad_iid) begin
                    status_q <= ST_ERR_IFACE;
                    data_q   <= '0;
                end else if (bad_func) begin
                    status_q <= ST_ERR_FUNC;
                    data_q   <= '0;
                end else if (div_zero) begin
                    status_q <= ST_OK;
                    data_q   <= req_function_id[0] ? req_data0 : '1;
                end
            end else if (state == S_BUSY) begin
                rem <= rem_next;
                quo <= quo_next;
                cnt <= cnt - CNT_LAST;
                // The last step's result is captured on the same edge that enters RESP.
                if (cnt == CNT_LAST) begin
                    status_q <= ST_OK;
                    data_q   <= func_rem ? rem_next : quo_next;
                end
            end
        end
    end

    always_comb begin
        req_ready   = (state == S_IDLE) && reset;
        resp_valid  = (state == S_RESP);
        resp_id     = id_q;
        resp_status = status_q;
        resp_data   = data_q;
    end

endmodule

// File: tb/tb_cfu_idiv_responder.sv
// Bench for cfu_idiv_responder: directed vector table, handshake corner cases,
// and randomized traffic checked against a plain-arithmetic divide model.
`timescale 1ns/1ps
module tb_cfu_idiv_responder;

    localparam logic [15:0] IID_OK  = 16'd1001;
    localparam logic [15:0] IID_BAD = 16'd1000;

    logic        clock = 1'b0;
    logic        reset, clock_en;
    logic        req_valid, req_ready;
    logic [15:0] req_interface_id;
    logic [0:0]  req_function_id;
    logic [5:0]  req_id;
    logic [31:0] req_data0, req_data1;
    logic        resp_valid, resp_ready;
    logic [5:0]  resp_id;
    logic [1:0]  resp_status;
    logic [31:0] resp_data;

    cfu_idiv_responder dut (
        .clock            (clock),
        .reset            (reset),
        .clock_en         (clock_en),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_interface_id (req_interface_id),
        .req_function_id  (req_function_id),
        .req_id           (req_id),
        .req_data0        (req_data0),
        .req_data1        (req_data1),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_id          (resp_id),
        .resp_status      (resp_status),
        .resp_data        (resp_data)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] iid;
        logic        fid;
        logic [5:0]  id;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  status;
        logic [31:0] data;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input logic [15:0] iid, input logic fid, input logic [5:0] id,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [1:0] status, input logic [31:0] data, input int lat);
        vec_t v;
        v.iid = iid; v.fid = fid; v.id = id; v.a = a; v.b = b;
        v.status = status; v.data = data; v.lat = lat;
        return v;
    endfunction

    // Reference: {id, status, data} from the architectural rules, RISC-V divide-by-zero semantics.
    function automatic logic [39:0] model(input logic [15:0] iid, input logic fid, input logic [5:0] id,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [1:0]  st;
        logic [31:0] d;
        if (iid != IID_OK) begin
            st = 2'd1; d = 32'd0;
        end else if (b == 32'd0) begin
            st = 2'd0; d = fid ? a : 32'hFFFF_FFFF;
        end else begin
            st = 2'd0; d = fid ? (a % b) : (a / b);
        end
        return {id, st, d};
    endfunction

    task automatic drive_req(input vec_t v);
        req_valid        = 1'b1;
        req_interface_id = v.iid;
        req_function_id  = v.fid;
        req_id           = v.id;
        req_data0        = v.a;
        req_data1        = v.b;
    endtask

    // Latency counts edges from the accept edge (inclusive) until resp_valid is seen.
    task automatic run_txn(input string tag, input vec_t v, input int hold);
        int lat;
        lat = 0;
        while (!req_ready && lat < 100) begin tick(); lat++; end
        check($sformatf("%s_req_ready", tag), 64'(req_ready), 64'(1));
        drive_req(v);
        resp_ready = (hold == 0);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin tick(); lat++; end
        check($sformatf("%s_latency", tag), 64'(lat), 64'(v.lat));
        check($sformatf("%s_status", tag), 64'(resp_status), 64'(v.status));
        check($sformatf("%s_data", tag), 64'(resp_data), 64'(v.data));
        check($sformatf("%s_id", tag), 64'(resp_id), 64'(v.id));
        for (int i = 0; i < hold; i++) begin
            tick();
            check($sformatf("%s_hold%0d", tag, i),
                  64'({resp_valid, req_ready, resp_id, resp_status, resp_data}),
                  64'({1'b1, 1'b0, v.id, v.status, v.data}));
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check($sformatf("%s_released", tag), 64'({resp_valid, req_ready}), 64'(2'b01));
    endtask

    initial begin
        int          lat, seen, guard;
        logic        accepted, done;
        logic [39:0] got, exp;
        vec_t        v;

        vecs[0]  = mk(IID_OK,  1'b0, 6'd5,  32'd100,          32'd7,          2'd0, 32'd14,           33);
        vecs[1]  = mk(IID_OK,  1'b1, 6'd5,  32'd100,          32'd7,          2'd0, 32'd2,            33);
        vecs[2]  = mk(IID_OK,  1'b0, 6'd6,  32'hFFFF_FFFF,    32'd1,          2'd0, 32'hFFFF_FFFF,    33);
        vecs[3]  = mk(IID_OK,  1'b1, 6'd7,  32'h8000_0000,    32'hFFFF_FFFF,  2'd0, 32'h8000_0000,    33);
        vecs[4]  = mk(IID_OK,  1'b0, 6'd8,  32'd0,            32'd9,          2'd0, 32'd0,            33);
        vecs[5]  = mk(IID_OK,  1'b0, 6'd9,  32'd5,            32'd0,          2'd0, 32'hFFFF_FFFF,    1);
        vecs[6]  = mk(IID_OK,  1'b1, 6'd10, 32'd5,            32'd0,          2'd0, 32'd5,            1);
        vecs[7]  = mk(IID_BAD, 1'b0, 6'd11, 32'd100,          32'd7,          2'd1, 32'd0,            1);
        vecs[8]  = mk(IID_OK,  1'b0, 6'd12, 32'd100,          32'd7,          2'd0, 32'd14,           33);
        vecs[9]  = mk(IID_OK,  1'b0, 6'd63, 32'hDEAD_BEEF,    32'h10,         2'd0, 32'h0DEA_DBEE,    33);
        vecs[10] = mk(IID_OK,  1'b1, 6'd0,  32'hDEAD_BEEF,    32'h10,         2'd0, 32'hF,            33);

        reset = 1'b0; clock_en = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_interface_id = '0; req_function_id = '0; req_id = '0; req_data0 = '0; req_data1 = '0;

        // Reset state
        tick(); tick();
        check("reset_req_ready", 64'(req_ready), 64'(0));
        check("reset_resp_valid", 64'(resp_valid), 64'(0));
        check("reset_resp_fields", 64'({resp_id, resp_status, resp_data}), 64'(0));
        reset = 1'b1;
        #1;
        check("post_reset_req_ready", 64'(req_ready), 64'(1));
        tick();

        foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i], 0);

        // Response held under backpressure for 10 cycles
        run_txn("backpressure", vecs[1], 10);

        // clock_en low blocks the accept, then stretches BUSY by 5 cycles, then freezes RESP
        v = mk(IID_OK, 1'b0, 6'd20, 32'd1000, 32'd10, 2'd0, 32'd100, 38);
        drive_req(v);
        clock_en = 1'b0;
        tick();
        check("ce_no_accept", 64'({req_ready, resp_valid}), 64'(2'b10));
        clock_en = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            clock_en = !(lat >= 10 && lat < 15);
            tick(); lat++;
        end
        clock_en = 1'b1;
        check("ce_latency", 64'(lat), 64'(v.lat));
        check("ce_data", 64'({resp_id, resp_status, resp_data}), 64'({v.id, v.status, v.data}));
        resp_ready = 1'b1;
        clock_en   = 1'b0;
        repeat (3) tick();
        check("ce_resp_frozen", 64'({resp_valid, req_ready, resp_data}), 64'({1'b1, 1'b0, v.data}));
        clock_en = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("ce_released", 64'({resp_valid, req_ready}), 64'(2'b01));

        // Reset at BUSY step 12 drops the request
        drive_req(vecs[0]);
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (11) tick();
        reset = 1'b0;
        tick();
        check("midreset_req_ready_low", 64'(req_ready), 64'(0));
        reset = 1'b1;
        #1;
        check("midreset_idle", 64'({req_ready, resp_valid}), 64'(2'b10));
        seen = 0;
        repeat (50) begin tick(); if (resp_valid) seen++; end
        check("midreset_no_resp", 64'(seen), 64'(0));
        run_txn("after_midreset", vecs[8], 0);

        // Randomized traffic with backpressure and clock_en gaps
        for (int t = 0; t < 1000; t++) begin
            v.iid = ($urandom_range(0, 15) == 0) ? IID_BAD : IID_OK;
            v.fid = 1'($urandom_range(0, 1));
            v.id  = 6'($urandom);
            v.a   = ($urandom_range(0, 3) == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
            case ($urandom_range(0, 7))
                0:       v.b = 32'd0;
                1:       v.b = $urandom_range(1, 16);
                2:       v.b = 32'hFFFF_FFFF;
                3:       v.b = v.a;
                default: v.b = $urandom >> $urandom_range(0, 31);
            endcase
            exp = model(v.iid, v.fid, v.id, v.a, v.b);

            drive_req(v);
            accepted = 1'b0;
            guard    = 0;
            while (!accepted && guard < 200) begin
                clock_en   = ($urandom_range(0, 7) != 0);
                resp_ready = 1'($urandom_range(0, 1));
                accepted   = req_ready && clock_en;
                tick(); guard++;
            end
            req_valid = 1'b0;

            done  = 1'b0;
            got   = '0;
            guard = 0;
            while (!done && guard < 400) begin
                clock_en   = ($urandom_range(0, 7) != 0);
                resp_ready = ($urandom_range(0, 3) != 0);
                if (resp_valid && resp_ready && clock_en) begin
                    got  = {resp_id, resp_status, resp_data};
                    done = 1'b1;
                end
                tick(); guard++;
            end
            check($sformatf("rand%0d a=%0h b=%0h f=%0d", t, v.a, v.b, v.fid),
                  64'({accepted, done, got}), 64'({1'b1, 1'b1, exp}));
        end
        clock_en   = 1'b1;
        resp_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
